// File: rtl/jtag_tap_master_pkg.sv
// Shared encodings, FSM states and TMS sequencing helpers for the JTAG TAP master.
package jtag_tap_master_pkg;

  localparam int LEN_W = 7;

  typedef enum logic [1:0] {
    OP_TAP_RESET   = 2'd0,
    OP_SCAN_IR     = 2'd1,
    OP_SCAN_DR     = 2'd2,
    OP_IDLE_CLOCKS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_AUTO_RST = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam logic [5:0]       RST_TMS    = 6'b011111;
  localparam logic [LEN_W-1:0] RST_LEN    = 7'd6;
  localparam logic [LEN_W-1:0] DR_PRE_LEN = 7'd3;
  localparam logic [LEN_W-1:0] IR_PRE_LEN = 7'd4;
  localparam logic [LEN_W-1:0] POST_LEN   = 7'd2;
  localparam logic [3:0]       DR_PRE_TMS = 4'b0001;
  localparam logic [3:0]       IR_PRE_TMS = 4'b0011;

  function automatic logic is_scan(op_e op);
    return (op == OP_SCAN_IR) || (op == OP_SCAN_DR);
  endfunction

  function automatic logic [LEN_W-1:0] pre_len(op_e op);
    return (op == OP_SCAN_IR) ? IR_PRE_LEN : DR_PRE_LEN;
  endfunction

  // Total TCK periods for a command; zero-length scans/idles produce no clocks.
  function automatic logic [LEN_W-1:0] seq_len(op_e op, logic [LEN_W-1:0] len);
    case (op)
      OP_TAP_RESET:   return RST_LEN;
      OP_IDLE_CLOCKS: return len;
      default:        return (len == '0) ? '0 : pre_len(op) + len + POST_LEN;
    endcase
  endfunction

  function automatic logic in_shift(op_e op, logic [LEN_W-1:0] len, logic [LEN_W-1:0] p);
    return is_scan(op) && (p >= pre_len(op)) && (p < pre_len(op) + len);
  endfunction

  // TMS for TCK period p: preamble, shifts (1 on the last), then Update(1), Idle(0).
  function automatic logic tms_at(op_e op, logic [LEN_W-1:0] len, logic [LEN_W-1:0] p);
    logic [LEN_W-1:0] pre, last;
    pre  = pre_len(op);
    last = pre + len - LEN_W'(1);
    case (op)
      OP_TAP_RESET:   return RST_TMS[p[2:0]];
      OP_IDLE_CLOCKS: return 1'b0;
      default: begin
        if (p < pre) return (op == OP_SCAN_IR) ? IR_PRE_TMS[p[1:0]] : DR_PRE_TMS[p[1:0]];
        else         return (p == last) || (p == last + LEN_W'(1));
      end
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_master_tck.sv
// TCK divider: toggles tck every CLK_DIV clk cycles, low half first, with
// single-cycle strobes on the cycle that precedes each tck edge.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          tc;

  assign tc = en && !clr && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (clr) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (en) begin
      if (cnt_q == TC) begin
        cnt_d = '0;
        tck_d = !tck_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck  = tck_q;
  assign rise = tc && !tck_q;
  assign fall = tc && tck_q;
endmodule

// File: rtl/jtag_tap_master.sv
// JTAG host: turns valid/ready commands into TCK/TMS/TDI sequences and returns
// the captured TDO bits as one response per command.
module jtag_tap_master
  import jtag_tap_master_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);
  localparam int IW = $clog2(MAX_LEN);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic               rise, fall;
  logic [LEN_W-1:0]   len_in, seq_k, nxt, cur_off, nxt_off;

  assign busy = (state_q == ST_AUTO_RST) || (state_q == ST_RUN);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy),
    .clr     (!busy),
    .tck     (tck),
    .rise    (rise),
    .fall    (fall)
  );

  assign len_in  = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign seq_k   = seq_len(op_q, len_q);
  assign nxt     = cnt_q + LEN_W'(1);
  assign cur_off = cnt_q - pre_len(op_q);
  assign nxt_off = nxt - pre_len(op_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          len_d  = len_in;
          data_d = cmd_data;
          cap_d  = '0;
          cnt_d  = '0;
          tdi_d  = 1'b0;
          if (seq_len(op_d, len_d) == '0) begin
            state_d = ST_RESP;
            rsp_d   = '0;
          end else begin
            state_d = ST_RUN;
            tms_d   = tms_at(op_d, len_d, '0);
          end
        end
      end
      // Auto-reset reuses the command sequencer with op_q forced to TAP_RESET.
      ST_AUTO_RST, ST_RUN: begin
        if (rise && in_shift(op_q, len_q, cnt_q))
          cap_d[cur_off[IW-1:0]] = tdo;
        if (fall) begin
          if (cnt_q == seq_k - LEN_W'(1)) begin
            cnt_d = '0;
            tdi_d = 1'b0;
            if (state_q == ST_RUN) begin
              state_d = ST_RESP;
              rsp_d   = cap_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = nxt;
            tms_d = tms_at(op_q, len_q, nxt);
            tdi_d = in_shift(op_q, len_q, nxt) ? data_q[nxt_off[IW-1:0]] : 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_AUTO_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_AUTO_RST;
      op_q    <= OP_TAP_RESET;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master against a behavioural TAP with BYPASS,
// a 4-bit IR and a 64-bit loopback data register (IR=2).
module tb_jtag_tap_master;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 64;
  localparam logic [63:0] INIT64 = 64'h1122334455667788;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_len = 7'd0;
  logic [63:0] cmd_data = 64'd0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [63:0] rsp_data;
  logic        tdo = 1'b0;

  int n_chk = 0, n_fail = 0;

  jtag_tap_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // ---------------- TAP target model ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_e;
  tap_e        ts = TLR;
  logic [3:0]  ir = 4'hF, ir_sr = 4'h0;
  logic        byp = 1'b0;
  logic [63:0] dr64 = INIT64;
  bit          tms_hist [1024];
  bit          tdi_hist [1024];
  int          tck_total = 0;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (ts)
      CAPDR: byp <= 1'b0;
      SHDR:  if (ir == 4'h2) dr64 <= {tdi, dr64[63:1]}; else byp <= tdi;
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
      UPIR:  ir <= ir_sr;
      TLR:   ir <= 4'hF;
      default: ;
    endcase
    ts <= tap_next(ts, tms);
    tms_hist[tck_total & 1023] <= tms;
    tdi_hist[tck_total & 1023] <= tdi;
    tck_total <= tck_total + 1;
  end

  always @(negedge tck)
    tdo <= (ts == SHDR) ? ((ir == 4'h2) ? dr64[0] : byp) : (ts == SHIR) ? ir_sr[0] : 1'b0;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [71:0] hist_vec(input int start, input int n, input bit use_tdi);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < n && k < 72; k++)
      v[k] = use_tdi ? tdi_hist[(start + k) & 1023] : tms_hist[(start + k) & 1023];
    return v;
  endfunction

  // Called at a negedge with reset_n low; releases it and checks the auto-reset.
  task automatic check_auto_reset(input string nm);
    int n, start;
    bit rsp_seen;
    start = tck_total;
    rsp_seen = 1'b0;
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid) rsp_seen = 1'b1;
    end while (!cmd_ready && n < 200);
    chk({nm, "_ready_cycles"}, 128'(n), 128'(12 * CLK_DIV));
    chk({nm, "_tck_pulses"}, 128'(tck_total - start), 128'(6));
    chk({nm, "_tms"}, 128'(hist_vec(start, 6, 1'b0)), 128'(6'b011111));
    chk({nm, "_no_rsp"}, 128'(rsp_seen), 128'(0));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  len;
    logic [63:0] data;
    logic [63:0] rsp;
    int          lat;
    int          ntck;
    logic [71:0] tms;
    int          pre;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int n, start;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({p, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
    start = tck_total;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = v.op;
    cmd_len = v.len;
    cmd_data = v.data;
    n = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n++;
    end while (!rsp_valid && n < 1000);
    chk({p, "_latency"}, 128'(n), 128'(v.lat));
    chk({p, "_rsp_data"}, 128'(rsp_data), 128'(v.rsp));
    chk({p, "_tck_pulses"}, 128'(tck_total - start), 128'(v.ntck));
    chk({p, "_tms"}, 128'(hist_vec(start, v.ntck, 1'b0)), 128'(v.tms));
    chk({p, "_tdi"}, 128'(hist_vec(start, v.ntck, 1'b1)), 128'(72'(v.data) << v.pre));
  endtask

  initial begin
    int n, start;
    bit ok;
    //           op    len    data                     rsp                      lat  ntck tms                      pre
    vecs[0] = '{2'd1, 7'd4,  64'hF,                   64'h1,                   41,  10,  72'h183,                 4};
    vecs[1] = '{2'd2, 7'd8,  64'hA5,                  64'h4A,                  53,  13,  72'hC01,                 3};
    vecs[2] = '{2'd1, 7'd4,  64'h2,                   64'h1,                   41,  10,  72'h183,                 4};
    vecs[3] = '{2'd2, 7'd64, 64'h0123456789ABCDEF,    INIT64,                  277, 69,  72'h0C_0000_0000_0000_0001, 3};
    vecs[4] = '{2'd2, 7'd70, 64'hFEDCBA9876543210,    64'h0123456789ABCDEF,    277, 69,  72'h0C_0000_0000_0000_0001, 3};
    vecs[5] = '{2'd2, 7'd0,  64'h0,                   64'h0,                   1,   0,   72'h0,                   0};
    vecs[6] = '{2'd3, 7'd3,  64'h0,                   64'h0,                   13,  3,   72'h0,                   0};
    vecs[7] = '{2'd0, 7'd9,  64'h0,                   64'h0,                   25,  6,   72'h1F,                  0};
    vecs[8] = '{2'd2, 7'd8,  64'hA5,                  64'h4A,                  53,  13,  72'hC01,                 3};

    repeat (4) @(negedge clk);
    chk("rst_tck", 128'(tck), 128'(0));
    chk("rst_tms", 128'(tms), 128'(1));
    chk("rst_tdi", 128'(tdi), 128'(0));
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_data", 128'(rsp_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(1));

    check_auto_reset("auto_rst");

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-pressure: response must hold while rsp_ready is low.
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    cmd_len = 7'd8;
    cmd_data = 64'hA5;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 128'(n), 128'(53));
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 64'h4A || cmd_ready || busy) ok = 1'b0;
    end
    chk("bp_hold_stable", 128'(ok), 128'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 128'(cmd_ready), 128'(1));
    chk("bp_release_valid", 128'(rsp_valid), 128'(0));

    // Reset during shift bit 5 of a DR scan.
    start = tck_total;
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    cmd_len = 7'd16;
    cmd_data = 64'hBEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while ((tck_total - start) < 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit5", 128'(tck_total - start), 128'(9));
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_tck", 128'(tck), 128'(0));
    chk("abort_tms", 128'(tms), 128'(1));
    chk("abort_tdi", 128'(tdi), 128'(0));
    chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("abort_rsp_data", 128'(rsp_data), 128'(0));
    chk("abort_cmd_ready", 128'(cmd_ready), 128'(0));
    repeat (2) @(negedge clk);
    check_auto_reset("re_auto_rst");
    run_vec(9, vecs[8]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
